// File: rtl/regfile_ctx_engine_pkg.sv
// rtl/regfile_ctx_engine_pkg.sv - shared defaults and state encoding for the context engine
package regfile_ctx_engine_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NREG       = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SAVE_RD   = 3'd1,
    ST_SAVE_PUSH = 3'd2,
    ST_RESTORE   = 3'd3,
    ST_FIN       = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_ctx_engine.sv
// rtl/regfile_ctx_engine.sv - register-file context save/restore engine
// Optional XOR checksum output enabled by CTX_CHECKSUM_EN.
module regfile_ctx_engine
  import regfile_ctx_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NREG       = DEF_NREG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  save_req,
  input  logic                  restore_req,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_addr_a,
  input  logic [DATA_WIDTH-1:0] rf_data_a,
  output logic [ADDR_WIDTH-1:0] rf_addr_d,
  output logic [DATA_WIDTH-1:0] rf_d,
  output logic                  rf_wrt_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready
`ifdef CTX_CHECKSUM_EN
  ,output logic [DATA_WIDTH-1:0] checksum
`endif
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  last_idx;

  assign last_idx  = (idx == ADDR_WIDTH'(NREG - 1));
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign in_ready  = (state == ST_RESTORE);
  assign rf_wrt_en = in_ready & in_valid;
  assign rf_addr_a = idx;
  assign rf_addr_d = idx;
  assign rf_d      = in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (save_req) begin
            state <= ST_SAVE_RD;
            idx   <= '0;
          end else if (restore_req) begin
            state <= ST_RESTORE;
            idx   <= '0;
          end
        end
        ST_SAVE_RD: begin
          out_data  <= rf_data_a;
          out_valid <= 1'b1;
          state     <= ST_SAVE_PUSH;
        end
        ST_SAVE_PUSH: begin
          // out_data is only reloaded in SAVE_RD, so it stays put while stalled
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_idx) begin
              state <= ST_FIN;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SAVE_RD;
            end
          end
        end
        ST_RESTORE: begin
          if (in_valid) begin
            if (last_idx) state <= ST_FIN;
            else          idx   <= idx + 1'b1;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CTX_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (state == ST_IDLE && (save_req || restore_req)) begin
      checksum <= '0;
    end else if (state == ST_SAVE_PUSH && out_valid && out_ready) begin
      checksum <= checksum ^ out_data;
    end else if (state == ST_RESTORE && in_valid) begin
      checksum <= checksum ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// tb/tb_regfile_ctx_engine.sv - randomized self-checking bench for regfile_ctx_engine
module tb_regfile_ctx_engine;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          save_req, restore_req;
  logic          busy, done;
  logic [AW-1:0] rf_addr_a, rf_addr_d;
  logic [DW-1:0] rf_data_a, rf_d;
  logic          rf_wrt_en;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
`ifdef CTX_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] rf     [NREG];
  logic [DW-1:0] ref_rf [NREG];
  logic          load_en;

  regfile_ctx_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .rf_addr_a(rf_addr_a), .rf_data_a(rf_data_a),
    .rf_addr_d(rf_addr_d), .rf_d(rf_d), .rf_wrt_en(rf_wrt_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
`ifdef CTX_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural register file seen by the engine
  assign rf_data_a = rf[rf_addr_a];
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < NREG; i++) rf[i] <= ref_rf[i];
    end else if (rf_wrt_en) begin
      rf[rf_addr_d] <= rf_d;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // rdy_mode: 0 always ready, 1 ready one cycle in three, 2 random
  task automatic run_save(input int rdy_mode, input bit both_req, input bit mid_restore);
    logic [DW-1:0] got[$];
    logic [DW-1:0] held = '0;
    logic [DW-1:0] xr = '0;
    bit  hold = 0;
    int  k = 0, done_k = -1, done_cnt = 0;
    int  stab_err = 0, busy_err = 0, wr_err = 0;
    @(negedge clk);
    save_req = 1'b1; restore_req = both_req;
    @(negedge clk);
    save_req = 1'b0; restore_req = 1'b0;
    while (k < 2000 && done_k < 0) begin
      out_ready   = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (k % 3 == 2) : 1'($urandom_range(0, 1));
      restore_req = mid_restore && (k == 10);
      #1;
      if (rf_wrt_en) wr_err++;
      if (!busy) busy_err++;
      if (hold && (!out_valid || out_data !== held)) stab_err++;
      if (done) begin done_cnt++; done_k = k; end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        hold = 0;
      end else if (out_valid) begin
        hold = 1; held = out_data;
      end else begin
        hold = 0;
      end
      @(negedge clk);
      k++;
    end
    restore_req = 1'b0;
    out_ready   = 1'b0;
    check("save_timeout", 32'(done_k >= 0), 32'd1);
    check("save_nwords", 32'(got.size()), 32'(NREG));
    for (int i = 0; i < NREG; i++) begin
      check($sformatf("save_word%0d", i), (i < got.size()) ? got[i] : 'x, ref_rf[i]);
      xr ^= ref_rf[i];
    end
    check("save_done_cnt", 32'(done_cnt), 32'd1);
    if (rdy_mode == 0) check("save_done_latency", 32'(done_k), 32'd64);
    check("save_stable", 32'(stab_err), 32'd0);
    check("save_busy", 32'(busy_err), 32'd0);
    check("save_no_wr", 32'(wr_err), 32'd0);
`ifdef CTX_CHECKSUM_EN
    check("save_checksum", checksum, xr);
`endif
    #1;
    check("save_idle_busy", {31'd0, busy}, 32'd0);
    check("save_idle_done", {31'd0, done}, 32'd0);
  endtask

  // vmode: 0 in_valid always high, 1 random; stop_after >= 0 leaves the transfer mid-way
  task automatic run_restore(input int vmode, input int stop_after, input bit seq);
    logic [DW-1:0] w[NREG];
    logic [DW-1:0] xr = '0;
    int k = 0, done_k = -1, done_cnt = 0, last_wr_k = -1, nsent = 0;
    int en_err = 0, rdy_err = 0, addr_err = 0, data_err = 0;
    bit exp_en;
    for (int i = 0; i < NREG; i++) w[i] = seq ? 32'h100 + 32'(i) : $urandom;
    @(negedge clk);
    restore_req = 1'b1;
    @(negedge clk);
    restore_req = 1'b0;
    while (k < 2000 && done_k < 0) begin
      if (stop_after >= 0 && nsent == stop_after) break;
      in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data  = (in_valid && nsent < NREG) ? w[nsent] : $urandom;
      #1;
      exp_en = in_valid && (nsent < NREG);
      if (in_ready !== (nsent < NREG)) rdy_err++;
      if (rf_wrt_en !== exp_en) en_err++;
      if (done) begin done_cnt++; done_k = k; end
      if (exp_en) begin
        if (rf_addr_d !== AW'(nsent)) addr_err++;
        if (rf_d !== w[nsent]) data_err++;
        xr ^= w[nsent];
        ref_rf[nsent] = w[nsent];
        nsent++;
        last_wr_k = k;
      end
      @(negedge clk);
      k++;
    end
    check("rst_en_match", 32'(en_err), 32'd0);
    check("rst_in_ready", 32'(rdy_err), 32'd0);
    check("rst_addr", 32'(addr_err), 32'd0);
    check("rst_data", 32'(data_err), 32'd0);
    if (stop_after < 0) begin
      in_valid = 1'b0;
      check("rst_timeout", 32'(done_k >= 0), 32'd1);
      check("rst_done_cnt", 32'(done_cnt), 32'd1);
      if (vmode == 0) check("rst_done_after_last", 32'(done_k - last_wr_k), 32'd1);
`ifdef CTX_CHECKSUM_EN
      check("rst_checksum", checksum, xr);
`endif
      #1;
      check("rst_idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int wr_after;
    rst_n = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < NREG; i++) ref_rf[i] = '0;
    ref_rf[1] = 32'd2; ref_rf[2] = 32'd2; ref_rf[3] = 32'hF0;
    load_en = 1'b1;
    repeat (2) @(posedge clk);
    load_en = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_wrt_en", {31'd0, rf_wrt_en}, 32'd0);
    check("reset_addr_a", 32'(rf_addr_a), 32'd0);
    check("reset_addr_d", 32'(rf_addr_d), 32'd0);
`ifdef CTX_CHECKSUM_EN
    check("reset_checksum", checksum, 32'd0);
`endif
    rst_n = 1'b1;

    run_save(0, 1'b0, 1'b0);
`ifdef CTX_CHECKSUM_EN
    check("init_checksum_f0", checksum, 32'h000000F0);
`endif
    run_save(1, 1'b0, 1'b0);
    run_restore(0, -1, 1'b1);
    run_save(2, 1'b0, 1'b0);
    run_save(2, 1'b1, 1'b1);
    run_restore(1, -1, 1'b0);
    run_save(1, 1'b0, 1'b0);

    // Reset after five restored words
    run_restore(0, 5, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_wrt_en", {31'd0, rf_wrt_en}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    wr_after = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (rf_wrt_en) wr_after++;
    end
    in_valid = 1'b0;
    check("midrst_no_writes", 32'(wr_after), 32'd0);
    check("midrst_r5_kept", rf[5], ref_rf[5]);
    run_save(0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_ctx_engine.md
Name: regfile_ctx_engine

Overview:
Context save/restore engine that acts as initiator on the register-file read/write interface.
- On a save request, reads all NREG registers in index order through read port A and streams them out on a valid/ready word stream.
- On a restore request, accepts NREG words from an input stream and writes them into registers 0..NREG-1 through the write port.
- Sits beside the core datapath and is used for task switch and debug snapshot.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, register/word width
NREG, 32, number of registers transferred (≤ 2^ADDR_WIDTH)

Ports:
clk  in  1  system clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
save_req  in  1  start save; sampled only in IDLE
restore_req  in  1  start restore; sampled only in IDLE
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of a transfer
rf_addr_a  out  ADDR_WIDTH  register-file read address A
rf_data_a  in  DATA_WIDTH  register-file read data A
rf_addr_d  out  ADDR_WIDTH  register-file write address
rf_d  out  DATA_WIDTH  register-file write data
rf_wrt_en  out  1  register-file write enable
out_data  out  DATA_WIDTH  save stream data
out_valid  out  1  save stream valid
out_ready  in  1  save stream ready
in_data  in  DATA_WIDTH  restore stream data
in_valid  in  1  restore stream valid
in_ready  out  1  restore stream ready

Behaviour:
- Interface: one clock; synchronous active-low reset on rst_n.
- Register-file timing contract:
  - Read: address is driven from a register. Read data is valid within the same cycle and is captured at that cycle's closing posedge.
  - Write: address, data and enable are presented during a cycle and commit at that cycle's closing posedge. rf_addr_d is driven from a register, so it is stable before the mid-cycle negedge.
- Reset: state=IDLE, idx=0, out_data=0, out_valid=0; busy/done/in_ready/rf_wrt_en=0; rf_addr_a=rf_addr_d=0.
- States: IDLE, SAVE_RD, SAVE_PUSH, RESTORE, FIN.
- IDLE:
  - save_req → SAVE_RD, idx=0.
  - Otherwise restore_req → RESTORE, idx=0.
  - Save wins if both requests are high.
- SAVE_RD (1 cycle):
  - rf_addr_a=idx.
  - At posedge: out_data←rf_data_a, out_valid←1, next state SAVE_PUSH.
- SAVE_PUSH:
  - out_valid=1. out_data is held stable until out_valid & out_ready.
  - On handshake: out_valid←0. If idx==NREG-1 → FIN, else idx←idx+1 → SAVE_RD.
  - Minimum 2 cycles per word.
- RESTORE:
  - in_ready=1, rf_addr_d=idx, rf_d=in_data.
  - rf_wrt_en = in_valid (combinational, gated by state).
  - On handshake: if idx==NREG-1 → FIN, else idx←idx+1.
  - One word per cycle at best.
- FIN: done=1 for exactly one cycle → IDLE.
- save_req/restore_req outside IDLE: ignored, not queued.
- rf_wrt_en is never high outside RESTORE.
- Register 0 is transferred like any other register; no hardwired zero is assumed.
- idx counts 0..NREG-1 and never wraps.
- Reset mid-transfer: immediate return to IDLE, stream outputs deasserted. Registers already written stay written; words already sent are not retracted.

Optional Feature:
CTX_CHECKSUM_EN
- Defined: adds output checksum [DATA_WIDTH].
  - Cleared on entry from IDLE into SAVE_RD or RESTORE.
  - XOR-accumulates every handshaken word (save or restore).
  - Holds its value after FIN until the next start.
  - Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared header: ADDR_WIDTH, DATA_WIDTH and NREG defaults, plus the state encoding constants (3-bit).
- No sub-module; a single FSM plus index counter. The checksum accumulator stays inline under the macro.

Test Plan:
- Save with out_ready=1, regfile initialised to r1=2, r2=2, r3=0xF0, others 0 → 32 words 0,2,2,0xF0,0,...,0 in order.
  - done pulses once, exactly 64 cycles after the first SAVE_RD cycle.
  - rf_wrt_en never high.
- Save with out_ready toggling 1-of-3 cycles → out_data stable while valid & !ready; no word lost or duplicated; order preserved.
- Restore words 0x100+i for i=0..31, in_valid always 1 → 32 consecutive rf_wrt_en cycles with rf_addr_d=i, rf_d=0x100+i; done one cycle after the last write. A follow-up save returns 0x100..0x11F.
- save_req and restore_req high together in IDLE → save performed. restore_req pulsed mid-save → ignored; busy stays high until FIN.
- rst_n low for one cycle after 5 restore words → next cycle IDLE, busy=0, in_ready=0, no further writes; registers 0..4 hold restored values, r5 unchanged.
- With CTX_CHECKSUM_EN, save of the initial regfile (r1=2, r2=2, r3=0xF0) → checksum=0x000000F0.
